spio_hss_multiplexer_frame_rx: RTL and testbench

//  Link-side receiver: takes aligned 32-bit words + K-flags from the GTP, checks CRC-16, splits control frames
//  (ack/nak, out-of-credit, channel flow control) from data frames. Data words stream to the frame disassembler;

---
 rtl/spio_hss_multiplexer_frame_rx.sv | 208 ++++++++++++++++++++
 tb/tb_spio_hss_multiplexer_frame_rx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spio_hss_multiplexer_frame_rx.sv
// HSS link receiver: CRC-16 checking, control-frame decode and
// data-frame payload streaming from aligned GTP words.
module spio_hss_multiplexer_frame_rx #(
  parameter logic [7:0] KCH_IDLE   = 8'hBC,
  parameter logic [7:0] KCH_DATA   = 8'hF7,
  parameter logic [7:0] KCH_ACK    = 8'hFB,
  parameter logic [7:0] KCH_NAK    = 8'hFD,
  parameter logic [7:0] KCH_OOC    = 8'hFE,
  parameter logic [7:0] KCH_CFC    = 8'h7C,
  parameter logic [3:0] CLKC_KBITS = 4'b1111,
  parameter logic [3:0] CTL_KBITS  = 4'b1000,
  parameter int MAX_WORDS = 8,
  parameter int CLR_BITS  = 3,
  parameter int SEQ_BITS  = 5,
  parameter int NUM_CHANS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          hsl_data,
  input  logic [3:0]           hsl_kchr,
  input  logic                 hsl_vld,
  output logic [31:0]          frm_data,
  output logic                 frm_vld,
  output logic                 frm_last,
  output logic                 frm_err,
  output logic                 ack_type,
  output logic [CLR_BITS-1:0]  ack_colour,
  output logic [SEQ_BITS-1:0]  ack_seq,
  output logic                 ack_vld,
  output logic [CLR_BITS-1:0]  ooc_colour,
  output logic                 ooc_vld,
  output logic [NUM_CHANS-1:0] cfc_rem,
  output logic                 cfc_vld,
  output logic [15:0]          reg_idsi,
  output logic                 reg_rfrm,
  output logic                 reg_crce
);

  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam logic [15:0] POLY = 16'h1021;

  typedef enum logic {IDLE_ST, DATA_ST} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [15:0]   crc, crc_nxt;

  logic [31:0] n_frm_data;
  logic n_frm_vld, n_frm_last, n_frm_err;
  logic n_ack_vld, n_ooc_vld, n_cfc_vld;
  logic n_idsi_we, n_rfrm, n_crce;
  logic dec;

  logic [7:0]  byte3;
  logic [7:0]  hdr_n;
  logic        is_ctl, hdr_ok;
  logic        ctl_ok, pay_ok;
  logic [31:0] crc_word_in;

  function automatic logic [15:0] crc_word(
    input logic [15:0] c,
    input logic [31:0] d
  );
    logic [15:0] r;
    r = c;
    for (int i = 31; i >= 0; i--)
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? POLY : 16'h0);
    return r;
  endfunction

  // CRC field of the frame's last word is taken as zero in the check
  assign crc_word_in = {hsl_data[31:16], 16'h0};
  assign byte3  = hsl_data[31:24];
  assign hdr_n  = hsl_data[23:16];
  assign is_ctl = (hsl_kchr == CTL_KBITS);
  assign hdr_ok = (hdr_n != 8'd0) && (hdr_n <= 8'(MAX_WORDS));
  assign ctl_ok = (crc_word(16'hFFFF, crc_word_in) == hsl_data[15:0]);
  assign pay_ok = (crc_word(crc, crc_word_in) == hsl_data[15:0]);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    crc_nxt    = crc;
    n_frm_data = '0;
    n_frm_vld  = 1'b0;
    n_frm_last = 1'b0;
    n_frm_err  = 1'b0;
    n_ack_vld  = 1'b0;
    n_ooc_vld  = 1'b0;
    n_cfc_vld  = 1'b0;
    n_idsi_we  = 1'b0;
    n_rfrm     = 1'b0;
    n_crce     = 1'b0;
    dec        = 1'b0;
    if (hsl_vld) begin
      if (state == DATA_ST) begin
        if (hsl_kchr != 4'b0000) begin
          n_frm_vld  = 1'b1;
          n_frm_last = 1'b1;
          n_frm_err  = 1'b1;
          n_crce     = 1'b1;
          state_nxt  = IDLE_ST;
          dec        = 1'b1;
        end else begin
          n_frm_vld  = 1'b1;
          n_frm_data = hsl_data;
          cnt_nxt    = cnt - CW'(1);
          crc_nxt    = crc_word(crc, hsl_data);
          if (cnt == CW'(1)) begin
            n_frm_last = 1'b1;
            n_frm_err  = !pay_ok;
            n_rfrm     = pay_ok;
            n_crce     = !pay_ok;
            state_nxt  = IDLE_ST;
          end
        end
      end else begin
        dec = 1'b1;
      end
      // aborting word falls through here and is decoded as idle input
      if (dec && is_ctl) begin
        unique case (1'b1)
          byte3 == KCH_IDLE: n_idsi_we = 1'b1;
          byte3 == KCH_ACK,
          byte3 == KCH_NAK: begin
            n_ack_vld = ctl_ok;
            n_rfrm    = n_rfrm | ctl_ok;
            n_crce    = n_crce | !ctl_ok;
          end
          byte3 == KCH_OOC: begin
            n_ooc_vld = ctl_ok;
            n_rfrm    = n_rfrm | ctl_ok;
            n_crce    = n_crce | !ctl_ok;
          end
          byte3 == KCH_CFC: begin
            n_cfc_vld = ctl_ok;
            n_rfrm    = n_rfrm | ctl_ok;
            n_crce    = n_crce | !ctl_ok;
          end
          byte3 == KCH_DATA: begin
            if (hdr_ok) begin
              state_nxt = DATA_ST;
              cnt_nxt   = hdr_n[CW-1:0];
              crc_nxt   = crc_word(16'hFFFF, hsl_data);
            end else begin
              n_crce = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE_ST;
      cnt   <= '0;
      crc   <= 16'hFFFF;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      crc   <= crc_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_data   <= '0;
      frm_vld    <= 1'b0;
      frm_last   <= 1'b0;
      frm_err    <= 1'b0;
      ack_type   <= 1'b0;
      ack_colour <= '0;
      ack_seq    <= '0;
      ack_vld    <= 1'b0;
      ooc_colour <= '0;
      ooc_vld    <= 1'b0;
      cfc_rem    <= '0;
      cfc_vld    <= 1'b0;
      reg_idsi   <= 16'h0;
      reg_rfrm   <= 1'b0;
      reg_crce   <= 1'b0;
    end else begin
      frm_data <= n_frm_data;
      frm_vld  <= n_frm_vld;
      frm_last <= n_frm_last;
      frm_err  <= n_frm_err;
      ack_vld  <= n_ack_vld;
      ooc_vld  <= n_ooc_vld;
      cfc_vld  <= n_cfc_vld;
      reg_rfrm <= n_rfrm;
      reg_crce <= n_crce;
      if (n_ack_vld) begin
        ack_type   <= (byte3 == KCH_ACK);
        ack_colour <= hsl_data[23 -: CLR_BITS];
        ack_seq    <= hsl_data[23-CLR_BITS -: SEQ_BITS];
      end
      if (n_ooc_vld)
        ooc_colour <= hsl_data[23 -: CLR_BITS];
      if (n_cfc_vld)
        cfc_rem <= hsl_data[16 +: NUM_CHANS];
      if (n_idsi_we)
        reg_idsi <= hsl_data[15:0];
    end
  end

endmodule

// File: tb/tb_spio_hss_multiplexer_frame_rx.sv
// Scoreboard bench for the HSS frame receiver: expected output
// events are queued per word and popped by a negedge monitor.
module tb_spio_hss_multiplexer_frame_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] hsl_data = '0;
  logic [3:0]  hsl_kchr = '0;
  logic        hsl_vld = 1'b0;
  logic [31:0] frm_data;
  logic        frm_vld, frm_last, frm_err;
  logic        ack_type, ack_vld;
  logic [2:0]  ack_colour;
  logic [4:0]  ack_seq;
  logic [2:0]  ooc_colour;
  logic        ooc_vld;
  logic [7:0]  cfc_rem;
  logic        cfc_vld;
  logic [15:0] reg_idsi;
  logic        reg_rfrm, reg_crce;

  spio_hss_multiplexer_frame_rx dut (
    .clk(clk), .rst(rst),
    .hsl_data(hsl_data), .hsl_kchr(hsl_kchr), .hsl_vld(hsl_vld),
    .frm_data(frm_data), .frm_vld(frm_vld),
    .frm_last(frm_last), .frm_err(frm_err),
    .ack_type(ack_type), .ack_colour(ack_colour),
    .ack_seq(ack_seq), .ack_vld(ack_vld),
    .ooc_colour(ooc_colour), .ooc_vld(ooc_vld),
    .cfc_rem(cfc_rem), .cfc_vld(cfc_vld),
    .reg_idsi(reg_idsi), .reg_rfrm(reg_rfrm), .reg_crce(reg_crce)
  );

  always #5 clk = ~clk;

  localparam int K_FRM = 0, K_ACK = 1, K_OOC = 2;
  localparam int K_CFC = 3, K_RFRM = 4, K_CRCE = 5;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
  } ev_t;

  ev_t q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  function automatic string kname(int k);
    case (k)
      K_FRM:   return "frm";
      K_ACK:   return "ack";
      K_OOC:   return "ooc";
      K_CFC:   return "cfc";
      K_RFRM:  return "rfrm";
      default: return "crce";
    endcase
  endfunction

  function automatic logic [15:0] crc_w(
    input logic [15:0] c,
    input logic [31:0] d
  );
    logic [15:0] r;
    r = c;
    for (int i = 31; i >= 0; i--)
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0);
    return r;
  endfunction

  function automatic logic [31:0] mk_ctl(
    input logic [7:0] k,
    input logic [7:0] b2
  );
    return {k, b2, crc_w(16'hFFFF, {k, b2, 16'h0})};
  endfunction

  task automatic expect_ev(int k, logic [31:0] a, logic [31:0] b);
    ev_t e;
    e.kind = k;
    e.a = a;
    e.b = b;
    q.push_back(e);
  endtask

  task automatic sb_check(int k, logic [31:0] a, logic [31:0] b);
    ev_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: unexpected event a=%h b=%h, required none",
               kname(k), a, b);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.a !== a || e.b !== b) begin
        n_bad++;
        $display("FAIL %s: got %s a=%h b=%h, required %s a=%h b=%h",
                 kname(k), kname(k), a, b, kname(e.kind), e.a, e.b);
      end
    end
  endtask

  always @(negedge clk) begin
    if (frm_vld) sb_check(K_FRM, frm_data, {30'd0, frm_last, frm_err});
    if (ack_vld) sb_check(K_ACK, {23'd0, ack_type, ack_colour, ack_seq}, 0);
    if (ooc_vld) sb_check(K_OOC, {29'd0, ooc_colour}, 0);
    if (cfc_vld) sb_check(K_CFC, {24'd0, cfc_rem}, 0);
    if (reg_rfrm) sb_check(K_RFRM, 0, 0);
    if (reg_crce) sb_check(K_CRCE, 0, 0);
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic send(logic [31:0] w, logic [3:0] k);
    hsl_data = w;
    hsl_kchr = k;
    hsl_vld  = 1'b1;
    @(posedge clk);
    #1;
    hsl_vld  = 1'b0;
    hsl_kchr = 4'b0000;
  endtask

  task automatic gap(int n);
    hsl_vld = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] w, h, p1, p2, p3, p4;
  logic [15:0] c;

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_frm_vld", {31'd0, frm_vld}, 0);
    chk("rst_ack_vld", {31'd0, ack_vld}, 0);
    chk("rst_cfc_rem", {24'd0, cfc_rem}, 0);
    chk("rst_idsi", {16'd0, reg_idsi}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    gap(1);

    // idle sentinel words
    repeat (3) send(32'hBC00_1234, 4'b1000);
    gap(1);
    chk("idsi", {16'd0, reg_idsi}, 32'h1234);

    // ack good, ack bad CRC, nak good, ooc good
    w = mk_ctl(8'hFB, {3'd5, 5'd17});
    send(w, 4'b1000);
    expect_ev(K_ACK, {23'd0, 1'b1, 3'd5, 5'd17}, 0);
    expect_ev(K_RFRM, 0, 0);
    send(w ^ 32'h1, 4'b1000);
    expect_ev(K_CRCE, 0, 0);
    send(mk_ctl(8'hFD, {3'd2, 5'd3}), 4'b1000);
    expect_ev(K_ACK, {23'd0, 1'b0, 3'd2, 5'd3}, 0);
    expect_ev(K_RFRM, 0, 0);
    send(mk_ctl(8'hFE, {3'd6, 5'd0}), 4'b1000);
    expect_ev(K_OOC, 32'd6, 0);
    expect_ev(K_RFRM, 0, 0);
    gap(2);

    // data frame N=3 with a 2-cycle hsl_vld gap
    h  = 32'hF703_0000;
    p1 = 32'h1111_2222;
    p2 = 32'h3333_4444;
    c  = crc_w(crc_w(crc_w(16'hFFFF, h), p1), p2);
    p3 = {16'h5555, crc_w(c, 32'h5555_0000)};
    send(h, 4'b1000);
    send(p1, 4'b0000);
    expect_ev(K_FRM, p1, 0);
    send(p2, 4'b0000);
    expect_ev(K_FRM, p2, 0);
    gap(2);
    send(p3, 4'b0000);
    expect_ev(K_FRM, p3, 32'b10);
    expect_ev(K_RFRM, 0, 0);

    // same frame with corrupted CRC
    send(h, 4'b1000);
    send(p1, 4'b0000);
    expect_ev(K_FRM, p1, 0);
    send(p2, 4'b0000);
    expect_ev(K_FRM, p2, 0);
    send(p3 ^ 32'h8000, 4'b0000);
    expect_ev(K_FRM, p3 ^ 32'h8000, 32'b11);
    expect_ev(K_CRCE, 0, 0);
    gap(2);

    // N=4 frame aborted by a CFC control word
    send(32'hF704_0000, 4'b1000);
    send(p1, 4'b0000);
    expect_ev(K_FRM, p1, 0);
    send(p2, 4'b0000);
    expect_ev(K_FRM, p2, 0);
    send(mk_ctl(8'h7C, 8'hA5), 4'b1000);
    expect_ev(K_FRM, 0, 32'b11);
    expect_ev(K_CFC, 32'hA5, 0);
    expect_ev(K_RFRM, 0, 0);
    expect_ev(K_CRCE, 0, 0);
    send(mk_ctl(8'hFB, {3'd1, 5'd2}), 4'b1000);
    expect_ev(K_ACK, {23'd0, 1'b1, 3'd1, 5'd2}, 0);
    expect_ev(K_RFRM, 0, 0);
    gap(2);

    // bad lengths, clock correction and stray data word in idle
    send(32'hF700_0000, 4'b1000);
    expect_ev(K_CRCE, 0, 0);
    send(32'hBCBC_BCBC, 4'b1111);
    send(32'hDEAD_BEEF, 4'b0000);
    send(32'hF709_0000, 4'b1000);
    expect_ev(K_CRCE, 0, 0);
    gap(2);

    // N=8 frame (upper length bound)
    h = 32'hF708_0000;
    send(h, 4'b1000);
    c = crc_w(16'hFFFF, h);
    for (int i = 0; i < 7; i++) begin
      p4 = {8'h40 + 8'(i), 24'h00_A5A5};
      c  = crc_w(c, p4);
      send(p4, 4'b0000);
      expect_ev(K_FRM, p4, 0);
    end
    p4 = {16'h4747, crc_w(c, 32'h4747_0000)};
    send(p4, 4'b0000);
    expect_ev(K_FRM, p4, 32'b10);
    expect_ev(K_RFRM, 0, 0);
    gap(2);

    // reset during word 2 of a 5-word frame
    send(32'hF705_0000, 4'b1000);
    send(p1, 4'b0000);
    expect_ev(K_FRM, p1, 0);
    gap(1);
    hsl_data = p2;
    hsl_kchr = 4'b0000;
    hsl_vld  = 1'b1;
    #2 rst = 1'b1;
    @(negedge clk);
    hsl_vld = 1'b0;
    chk("rst_mid_frm_vld", {31'd0, frm_vld}, 0);
    chk("rst_mid_frm_last", {31'd0, frm_last}, 0);
    chk("rst_mid_idsi", {16'd0, reg_idsi}, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    gap(1);
    h  = 32'hF701_0000;
    p3 = {16'h9999, crc_w(crc_w(16'hFFFF, h), 32'h9999_0000)};
    send(h, 4'b1000);
    send(p3, 4'b0000);
    expect_ev(K_FRM, p3, 32'b10);
    expect_ev(K_RFRM, 0, 0);
    gap(4);

    chk("sb_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
